// File: rtl/proc_io_pkg.sv
// rtl/proc_io_pkg.sv - shared constants and input FSM state type for the processor I/O bridge
package proc_io_pkg;

    localparam int DATA_W      = 8;
    localparam int FIFO_DEPTH  = 4;
    localparam int INTR_CYCLES = 2;
    localparam int HOLD_CYCLES = 8;
    localparam int CNT_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2
    } in_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with memory-read head, zero head when empty
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    // A pop frees the slot this cycle, so a full FIFO still accepts a simultaneous push.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/proc_io_bridge.sv
// rtl/proc_io_bridge.sv - host-to-pins byte delivery with interrupt pulse, and pin-change capture FIFO
module proc_io_bridge
    import proc_io_pkg::*;
#(
    parameter int DATA_W      = proc_io_pkg::DATA_W,
    parameter int FIFO_DEPTH  = proc_io_pkg::FIFO_DEPTH,
    parameter int INTR_CYCLES = proc_io_pkg::INTR_CYCLES,
    parameter int HOLD_CYCLES = proc_io_pkg::HOLD_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] port_in_pins,
    output logic              intr_out,
    input  logic [DATA_W-1:0] port_out_pins,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              ovf,
    input  logic              ovf_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);

    in_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] pins_d;

    logic [DATA_W-1:0] sample_q;
    logic [DATA_W-1:0] last_q;
    logic              cap_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [AW:0]       fifo_count;
    logic              ovf_set;

    assign in_ready = (state_q == ST_IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pins_d  = port_in_pins;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    pins_d  = in_data;
                    cnt_d   = CNT_W'(INTR_CYCLES - 1);
                    state_d = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    if (HOLD_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = CNT_W'(HOLD_CYCLES);
                        state_d = ST_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            port_in_pins <= '0;
            intr_out     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            port_in_pins <= pins_d;
            intr_out     <= (state_d == ST_PULSE);
        end
    end

    // last_q advances even when the push is dropped, so an overflowed value is not retried.
    assign cap_push  = (sample_q != last_q);
    assign fifo_pop  = out_ready && (fifo_count != '0);
    assign out_valid = !fifo_empty;
    assign ovf_set   = cap_push && fifo_full && !fifo_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q <= '0;
            last_q   <= '0;
            ovf      <= 1'b0;
        end else begin
            sample_q <= port_out_pins;
            if (cap_push) begin
                last_q <= sample_q;
            end
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cap_push),
        .push_data (sample_q),
        .pop       (fifo_pop),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_proc_io_bridge.sv
// tb/tb_proc_io_bridge.sv - directed and randomized bench for proc_io_bridge against a timing/queue model
module tb_proc_io_bridge;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int IC    = 2;
    localparam int HC    = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] port_in_pins;
    logic          intr_out;
    logic [DW-1:0] port_out_pins = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          ovf;
    logic          ovf_clr = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: delivery is a byte plus "cycles of interrupt left" and "cycles busy left";
    // capture is a value seen one edge ago compared with the last recorded value, feeding a queue.
    logic [DW-1:0] m_pins = '0;
    int            m_intr_left = 0;
    int            m_busy = 0;
    logic [DW-1:0] m_samp = '0;
    logic [DW-1:0] m_last = '0;
    logic [DW-1:0] m_q[$];
    bit            m_ovf = 1'b0;
    logic [DW-1:0] dut_popped[$];

    always #5 clk = ~clk;

    proc_io_bridge #(
        .DATA_W      (DW),
        .FIFO_DEPTH  (DEPTH),
        .INTR_CYCLES (IC),
        .HOLD_CYCLES (HC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .port_in_pins  (port_in_pins),
        .intr_out      (intr_out),
        .port_out_pins (port_out_pins),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .ovf           (ovf),
        .ovf_clr       (ovf_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit pop;
        bit push;
        bit drop;
        if (out_valid && out_ready) dut_popped.push_back(out_data);
        @(posedge clk);
        if (rst) begin
            m_pins = '0; m_intr_left = 0; m_busy = 0;
            m_samp = '0; m_last = '0; m_q.delete(); m_ovf = 1'b0;
        end else begin
            if (m_busy == 0 && in_valid) begin
                m_pins = in_data;
                m_intr_left = IC;
                m_busy = IC + HC;
            end else begin
                if (m_busy > 0) m_busy--;
                if (m_intr_left > 0) m_intr_left--;
            end
            pop  = (m_q.size() > 0) && out_ready;
            push = (m_samp != m_last);
            drop = push && (m_q.size() == DEPTH) && !pop;
            if (push) m_last = m_samp;
            if (pop) void'(m_q.pop_front());
            if (push && !drop) m_q.push_back(m_samp);
            if (drop) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            m_samp = port_out_pins;
        end
        #1;
        chk("port_in_pins", 32'(port_in_pins), 32'(m_pins));
        chk("intr_out", 32'(intr_out), 32'(m_intr_left > 0));
        chk("in_ready", 32'(in_ready), 32'(m_busy == 0));
        chk("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        chk("out_data", 32'(out_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0);
        chk("ovf", 32'(ovf), 32'(m_ovf));
    endtask

    initial begin
        logic [DW-1:0] exp_seq[$];
        bit            seen;

        // Reset held for three cycles with quiet pins.
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_in_ready", 32'(in_ready), 32'h1);
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        rst = 1'b0;
        tick();

        // Delivery of 0x77, then 0x55 offered back-to-back; accepted at k+11.
        in_valid = 1'b1; in_data = 8'h77;
        tick();
        chk("deliver_pins", 32'(port_in_pins), 32'h77);
        chk("deliver_intr", 32'(intr_out), 32'h1);
        in_data = 8'h55;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("deliver_hold", 32'(port_in_pins), 32'h77);
        end
        tick();
        chk("second_accept", 32'(port_in_pins), 32'h55);
        in_valid = 1'b0;
        repeat (12) tick();

        // Change capture with a return to an earlier value.
        out_ready = 1'b1;
        dut_popped.delete();
        port_out_pins = 8'h77; repeat (5) tick();
        port_out_pins = 8'h55; repeat (3) tick();
        port_out_pins = 8'h77; repeat (5) tick();
        exp_seq = '{8'h77, 8'h55, 8'h77};
        chk("capture_count", 32'(dut_popped.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            chk("capture_value", (i < dut_popped.size()) ? 32'(dut_popped[i]) : 32'hdead, 32'(exp_seq[i]));
        chk("capture_ovf", 32'(ovf), 32'h0);

        // Overflow: five values, only four fit.
        out_ready = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            port_out_pins = DW'(v);
            repeat (2) tick();
        end
        repeat (3) tick();
        chk("overflow_set", 32'(ovf), 32'h1);
        chk("overflow_head", 32'(out_data), 32'h01);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("overflow_clr", 32'(ovf), 32'h0);

        // Full FIFO: a new value arrives on the same edge as a pop.
        port_out_pins = 8'h06;
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("fullpp_ovf", 32'(ovf), 32'h0);
        chk("fullpp_head", 32'(out_data), 32'h02);
        dut_popped.delete();
        out_ready = 1'b1;
        repeat (6) tick();
        exp_seq = '{8'h02, 8'h03, 8'h04, 8'h06};
        chk("fullpp_count", 32'(dut_popped.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("fullpp_value", (i < dut_popped.size()) ? 32'(dut_popped[i]) : 32'hdead, 32'(exp_seq[i]));
        chk("fullpp_empty", 32'(out_valid), 32'h0);

        // Randomized traffic on both sides.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) == 0);
            in_data   = DW'($urandom);
            out_ready = ($urandom_range(0, 2) == 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 2) == 0) port_out_pins = DW'($urandom_range(0, 5) * 8'h11);
            tick();
        end
        in_valid = 1'b0; ovf_clr = 1'b0;

        // Reset on the first PULSE cycle.
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (in_ready) seen = 1'b1;
            else tick();
        end
        chk("idle_before_rst", 32'(seen), 32'h1);
        in_valid = 1'b1; in_data = 8'hA5;
        tick();
        in_valid = 1'b0;
        chk("pulse_before_rst", 32'(intr_out), 32'h1);
        rst = 1'b1;
        tick();
        chk("rst_mid_intr", 32'(intr_out), 32'h0);
        chk("rst_mid_pins", 32'(port_in_pins), 32'h0);
        chk("rst_mid_ready", 32'(in_ready), 32'h1);
        rst = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
